// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display path:
// glyph patterns, special character codes, scan phases.
package seg_pkg;

  typedef logic [7:0][4:0] frame_t;

  typedef enum logic [1:0] {
    PH_GUARD,
    PH_LIT,
    PH_DARK
  } phase_e;

  localparam logic [4:0] CODE_DASH  = 5'h10;
  localparam logic [4:0] CODE_BLANK = 5'h1F;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic int slot_cycles(
    input int clk_hz,
    input int scan_hz
  );
    return clk_hz / scan_hz;
  endfunction

endpackage

// File: rtl/seg_glyph_dec.sv
// 5-bit character code to active-low {dp,g..a} pattern.
// Ports: code (char code), dp (point enable), seg (pattern).
module seg_glyph_dec
  import seg_pkg::*;
(
  input  logic [4:0] code,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] base;

  always_comb begin
    base = SEG_BLANK;
    case (code)
      5'h00:     base = SEG_0;
      5'h01:     base = SEG_1;
      5'h02:     base = SEG_2;
      5'h03:     base = SEG_3;
      5'h04:     base = SEG_4;
      5'h05:     base = SEG_5;
      5'h06:     base = SEG_6;
      5'h07:     base = SEG_7;
      5'h08:     base = SEG_8;
      5'h09:     base = SEG_9;
      5'h0A:     base = SEG_A;
      5'h0B:     base = SEG_B;
      5'h0C:     base = SEG_C;
      5'h0D:     base = SEG_D;
      5'h0E:     base = SEG_E;
      5'h0F:     base = SEG_F;
      CODE_DASH: base = SEG_DASH;
      default:   base = SEG_BLANK;
    endcase
  end

  assign seg = dp ? (base & 8'h7F) : base;

endmodule

// File: rtl/seg_scan_unit.sv
// 8-digit multiplexed seven-segment driver with guard and PWM.
// Ports: clk, rst_n, display_data, dp_mask, bright in;
//        led_en, seg (active-low), frame_start out.
module seg_scan_unit
  import seg_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [39:0] display_data,
  input  logic [7:0]  dp_mask,
  input  logic [2:0]  bright,
  output logic [7:0]  led_en,
  output logic [7:0]  seg,
  output logic        frame_start
);

  localparam int SLOT_CYCLES = slot_cycles(CLK_HZ, SCAN_HZ);
  localparam int CW          = $clog2(SLOT_CYCLES);
  localparam int ACT         = SLOT_CYCLES - BLANK_CYCLES;

  typedef logic [CW:0] cnt_ext_t;

  // End of the lit window per brightness level, one extra bit
  // because the window may run to the very end of the slot.
  function automatic cnt_ext_t lit_end(input int b);
    return cnt_ext_t'(BLANK_CYCLES + ((ACT * (b + 1)) >> 3));
  endfunction

  localparam cnt_ext_t LIT_END [8] = '{
    lit_end(0), lit_end(1), lit_end(2), lit_end(3),
    lit_end(4), lit_end(5), lit_end(6), lit_end(7)
  };

  logic [CW-1:0] div_cnt;
  logic [2:0]    idx;
  frame_t        frame_buf;
  logic [7:0]    dp_buf;
  logic [2:0]    bright_buf;

  logic          slot_end;
  logic          latch;
  logic          in_guard;
  logic          in_lit;
  phase_e        phase;
  logic [7:0]    glyph;

  assign slot_end = div_cnt == CW'(SLOT_CYCLES - 1);
  assign latch    = (div_cnt == '0) && (idx == 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      idx         <= 3'd0;
      frame_start <= 1'b0;
      frame_buf   <= {8{CODE_BLANK}};
      dp_buf      <= 8'h00;
      bright_buf  <= 3'd7;
    end else begin
      div_cnt     <= slot_end ? '0 : div_cnt + CW'(1);
      frame_start <= latch;
      if (slot_end) begin
        idx <= idx + 3'd1;
      end
      if (latch) begin
        frame_buf  <= display_data;
        dp_buf     <= dp_mask;
        bright_buf <= bright;
      end
    end
  end

  assign in_guard = div_cnt < CW'(BLANK_CYCLES);
  assign in_lit   = !in_guard &&
                    ({1'b0, div_cnt} < LIT_END[bright_buf]);

  always_comb begin
    phase = PH_DARK;
    unique case (1'b1)
      in_guard: phase = PH_GUARD;
      in_lit:   phase = PH_LIT;
      default:  phase = PH_DARK;
    endcase
  end

  seg_glyph_dec u_glyph (
    .code (frame_buf[idx]),
    .dp   (dp_buf[idx]),
    .seg  (glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_en <= 8'hFF;
      seg    <= 8'hFF;
    end else if (phase == PH_LIT) begin
      led_en <= ~(8'd1 << idx);
      seg    <= glyph;
    end else begin
      led_en <= 8'hFF;
      seg    <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_seg_scan_unit.sv
// Scoreboard bench for seg_scan_unit: expected lit runs are
// queued by the stimulus and popped by a negedge monitor.
module tb_seg_scan_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [39:0] display_data;
  logic [7:0]  dp_mask;
  logic [2:0]  bright;
  logic [7:0]  led_en;
  logic [7:0]  seg;
  logic        frame_start;

  seg_scan_unit #(
    .CLK_HZ       (1600),
    .SCAN_HZ      (100),
    .BLANK_CYCLES (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .display_data (display_data),
    .dp_mask      (dp_mask),
    .bright       (bright),
    .led_en       (led_en),
    .seg          (seg),
    .frame_start  (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] led;
    logic [7:0] sg;
    logic [7:0] len;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int         cyc = 0;
  logic       in_run = 1'b0;
  logic       bad_run;
  logic [7:0] r_led;
  logic [7:0] r_seg;
  int         r_len;
  int         r_start;
  logic       have_start = 1'b0;
  logic       have_end = 1'b0;
  int         last_end;
  logic       have_fs = 1'b0;
  int         last_fs;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [63:0] segs,
                            input int len, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.led = ~(8'd1 << i);
      e.sg  = segs[8*i +: 8];
      e.len = len[7:0];
      sb.push_back(e);
    end
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 300);
    chk("frame_start_wait", int'(frame_start), 1);
  endtask

  // Monitor: one-hot, guard/dark blanking, run shape, frame period.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_run     = 1'b0;
      have_start = 1'b0;
      have_end   = 1'b0;
      have_fs    = 1'b0;
    end else begin
      checks++;
      if ($countones(~led_en) > 1) begin
        errors++;
        $display("FAIL onehot: led_en=%h", led_en);
      end
      if (frame_start) begin
        if (have_fs) chk("frame_period", cyc - last_fs, 128);
        have_fs = 1'b1;
        last_fs = cyc;
      end
      if (led_en != 8'hFF) begin
        if (!in_run) begin
          in_run  = 1'b1;
          r_led   = led_en;
          r_seg   = seg;
          r_len   = 0;
          bad_run = 1'b0;
          if (have_end) begin
            checks++;
            if (cyc - last_end < 2) begin
              errors++;
              $display("FAIL guard_gap: got %0d want >=2",
                       cyc - last_end);
            end
          end
          if (have_start) chk("slot_period", cyc - r_start, 16);
          r_start    = cyc;
          have_start = 1'b1;
        end else if (led_en != r_led || seg != r_seg) begin
          bad_run = 1'b1;
        end
        r_len++;
      end else begin
        chk("dark_seg", int'(seg), 8'hFF);
        if (in_run) begin
          in_run   = 1'b0;
          have_end = 1'b1;
          last_end = cyc;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL run_unexpected: led=%h seg=%h len=%0d",
                     r_led, r_seg, r_len);
          end else begin
            exp_t e;
            e = sb.pop_front();
            if (r_led != e.led || r_seg != e.sg ||
                r_len != int'(e.len) || bad_run) begin
              errors++;
              $display("FAIL run: got led=%h seg=%h len=%0d unstable=%0d want led=%h seg=%h len=%0d",
                       r_led, r_seg, r_len, bad_run,
                       e.led, e.sg, e.len);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Frame 1: slot1=0, slot0=3, bright 7
    display_data = {5'h1F, 5'h1F, 5'h1F, 5'h1F,
                    5'h1F, 5'h1F, 5'h00, 5'h03};
    dp_mask = 8'h00;
    bright  = 3'd7;
    push_frame(64'hFFFFFFFF_FFFFC0B0, 14, 8);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_led_en", int'(led_en), 8'hFF);
    chk("reset_seg", int'(seg), 8'hFF);
    chk("reset_fs", int'(frame_start), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("fs_after_release", int'(frame_start), 1);
    repeat (63) @(posedge clk);
    #1;

    // Frame 2: slot0 changed mid-frame to A, bright 3
    display_data = {5'h1F, 5'h1F, 5'h1F, 5'h1F,
                    5'h1F, 5'h1F, 5'h00, 5'h0A};
    bright = 3'd3;
    push_frame(64'hFFFFFFFF_FFFFC088, 7, 8);
    wait_fs();
    repeat (64) @(posedge clk);
    #1;

    // Frame 3: dash with dp, undefined code, bright 0
    display_data = {5'h1F, 5'h1F, 5'h1F, 5'h1F,
                    5'h15, 5'h10, 5'h00, 5'h0A};
    dp_mask = 8'h04;
    bright  = 3'd0;
    push_frame(64'hFFFFFFFF_FF3FC088, 1, 8);
    wait_fs();
    repeat (64) @(posedge clk);
    #1;

    // Frame 4: digits, dp on digit 7
    display_data = {5'h09, 5'h08, 5'h07, 5'h06,
                    5'h05, 5'h04, 5'h02, 5'h01};
    dp_mask = 8'h80;
    bright  = 3'd7;
    push_frame(64'h1080F882_9299A4F9, 14, 8);
    wait_fs();
    repeat (64) @(posedge clk);
    #1;

    // Frame 5: letters, blank with dp, bright 5
    display_data = {5'h1E, 5'h1F, 5'h0F, 5'h0E,
                    5'h0D, 5'h0C, 5'h0B, 5'h0A};
    dp_mask = 8'h41;
    bright  = 3'd5;
    push_frame(64'hFF7F8E86_A1C68308, 10, 8);
    wait_fs();
    repeat (64) @(posedge clk);
    #1;

    // Frame 6: same data, cut by reset during digit 5
    push_frame(64'hFF7F8E86_A1C68308, 10, 5);
    wait_fs();
    repeat (87) @(posedge clk);
    #1;
    chk("pre_reset_led_en", int'(led_en), 8'hDF);
    chk("pre_reset_seg", int'(seg), 8'h8E);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_led_en", int'(led_en), 8'hFF);
    chk("async_reset_seg", int'(seg), 8'hFF);
    chk("async_reset_fs", int'(frame_start), 0);
    chk("runs_before_reset", sb.size(), 0);
    sb.delete();

    // Frame 7: fresh latch after reset, bright 1
    display_data = {5'h10, 5'h02, 5'h09, 5'h05,
                    5'h01, 5'h04, 5'h01, 5'h03};
    dp_mask = 8'h00;
    bright  = 3'd1;
    push_frame(64'hBFA49092_F999F9B0, 3, 8);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("fs_after_rerelease", int'(frame_start), 1);
    chk("guard_after_rerelease", int'(led_en), 8'hFF);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_unit.md
Name: seg_scan_unit

Overview:
Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. Sits directly downstream of the character-display stage. Consumes its 40-bit packed character bus: 8 slots of 5-bit codes, slot 7 in bits [39:35] (leftmost digit), slot 0 in bits [4:0] (rightmost).
- Scans one digit at a time.
- Inserts an anti-ghosting blank guard between digits.
- Applies PWM brightness.
- Latches the input bus once per frame so a digit can never tear mid-frame.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
SCAN_HZ, 1000, digit-slot rate in Hz; SLOT_CYCLES = CLK_HZ/SCAN_HZ; frame rate = SCAN_HZ/8
BLANK_CYCLES, 100, guard cycles at the start of every slot with all digits off; must satisfy 1 <= BLANK_CYCLES and SLOT_CYCLES >= BLANK_CYCLES+8

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
display_data  in  40  packed 5-bit character codes, slot i = bits [5i+4:5i]
dp_mask  in  8  decimal-point enable per digit, bit i = digit i
bright  in  3  brightness level 0..7 (0 = dimmest, not off)
led_en  out  8  digit enables, active-low, bit i = digit i
seg  out  8  segment drives, active-low, {dp,g,f,e,d,c,b,a}
frame_start  out  1  one-cycle pulse when a new frame is latched

Behaviour:
- Reset is asynchronous and active-low on rst_n; single clock clk. While rst_n=0:
  - led_en=8'hFF, seg=8'hFF, frame_start=0.
  - div_cnt=0, idx=0.
  - frame_buf = all slots 5'h1F; dp_buf=0; bright_buf=7.
- Slot counter:
  - div_cnt counts 0..SLOT_CYCLES-1.
  - On the cycle with div_cnt=SLOT_CYCLES-1: div_cnt returns to 0 and idx increments, wrapping 7->0.
- Frame latch:
  - On every cycle with div_cnt=0 and idx=0, including the first cycle after reset release: frame_buf<=display_data, dp_buf<=dp_mask, bright_buf<=bright.
  - frame_start is registered and asserts for exactly the following cycle.
  - Input changes at any other time have no visible effect until the next frame.
- Slot phases, decided from (div_cnt, bright_buf). ON_LEN = ((SLOT_CYCLES-BLANK_CYCLES)*(bright_buf+1))>>3.
  - GUARD: div_cnt < BLANK_CYCLES. All digits off, seg=8'hFF.
  - LIT: BLANK_CYCLES <= div_cnt < BLANK_CYCLES+ON_LEN. led_en = ~(1<<idx); seg = glyph(frame_buf[idx], dp_buf[idx]).
  - DARK: remainder of the slot. Same as GUARD.
- Output timing:
  - led_en and seg are registered, so the phase computed from the counter state in cycle n appears on the outputs in cycle n+1. Latency is 1 cycle.
  - At most one led_en bit is ever low. Outputs never glitch within a cycle.
- Glyph map, active-low {dp,g..a}:
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E.
  - Code 5'h10 = dash (BF).
  - Codes 5'h11..5'h1F = blank (FF).
  - dp_buf[idx]=1 clears bit 7 during LIT only. A blank code with dp set shows 7F.
- Integer widths: ON_LEN is computed as a constant table of 8 entries at elaboration, with no runtime multiplier. div_cnt width = $clog2(SLOT_CYCLES).
- Reset mid-slot: outputs go to all-off immediately (asynchronous). The scan restarts at idx=0 with a fresh latch.

Decomposition:
- Package seg_pkg:
  - SEG_* glyph constants (16 hex plus DASH, BLANK).
  - Code constants CODE_BLANK=5'h1F and CODE_DASH=5'h10.
  - Function slot_cycles(CLK_HZ,SCAN_HZ).
- One combinational sub-module seg_glyph_dec: 5-bit code + dp -> 8-bit active-low pattern. Reused by any other display path.

Test Plan:
Use CLK_HZ=1600, SCAN_HZ=100, BLANK_CYCLES=2, giving SLOT_CYCLES=16 and an ON window of 14.
1. Reset held, then released with display_data = codes 7..0 = 1F,1F,1F,1F,1F,1F,00,03 -> all outputs FF during reset. Slot 0 LIT shows led_en=FE, seg=B0; slot 1 shows led_en=FD, seg=C0; slots 2-7 show seg=FF. frame_start pulses on cycle 1 after release.
2. bright=7 -> each slot shows exactly 14 LIT cycles after 2 guard cycles. bright=3 -> exactly 7 LIT cycles, then 7 DARK. bright=0 -> exactly 1 LIT cycle.
3. Change display_data slot 0 from 03 to 0A mid-frame (idx=4) -> digit 0 still shows B0 this frame, and shows 88 from the next frame (after the frame_start pulse).
4. Slot 2 = 10 with dp_mask=8'h04 -> digit 2 shows seg=3F. Slot 3 = 15 (undefined code) -> FF with led_en=F7 during LIT.
5. Continuous run of 3 frames -> frame_start period = 128 cycles; idx wraps 7->0. Checker asserts that at most one led_en bit is low and that led_en=FF on every GUARD cycle.
6. Assert rst_n=0 at idx=5 mid-LIT -> led_en=FF and seg=FF in the same cycle. After release, scan restarts at digit 0 with a new latch.
